// File: rtl/uart_frame_pkg.sv
// uart_frame shared types: FSM state, error codes, checksum width.
// Checksum support is selected by UART_FRAME_CSUM_EN.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        S_RX,
        S_TX_SEND,
        S_TX_WAIT,
        S_TX_DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MSGID = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_TRUNC = 2'd3;

    localparam int CSUM_W = 16;

endpackage

// File: rtl/uart_frame_csum.sv
// Resettable 16-bit byte accumulator; clear has priority over add.
// Instantiated by uart_frame only when UART_FRAME_CSUM_EN is defined.
module uart_frame_csum
    import uart_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add,
    input  logic [7:0]        din,
    output logic [CSUM_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + CSUM_W'(din);
        end
    end

endmodule

// File: rtl/uart_frame.sv
// Request/response frame engine between UART PHYs and a register bank.
// Define UART_FRAME_CSUM_EN to append/verify a 16-bit byte checksum.
module uart_frame
    import uart_frame_pkg::*;
#(
    parameter int          RX_BYTES       = 10,
    parameter int          TX_BYTES       = 10,
    parameter logic [31:0] MSGID          = 32'h74697277,
    parameter bit          MSGID_CHECK    = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_byte_valid,
    input  logic                  rx_eop,
    input  logic                  tx_busy,
    input  logic [TX_BYTES*8-1:0] tx_data,
    output logic [7:0]            tx_byte,
    output logic                  tx_start,
    output logic [RX_BYTES*8-1:0] rx_data,
    output logic                  sync,
    output logic                  tx_enable,
    output logic [15:0]           err_cnt,
    output logic [1:0]            last_err
);

`ifdef UART_FRAME_CSUM_EN
    localparam int CSUM_BYTES = 2;
`else
    localparam int CSUM_BYTES = 0;
`endif
    localparam int RX_TOTAL = RX_BYTES + CSUM_BYTES;
    localparam int TX_TOTAL = TX_BYTES + CSUM_BYTES;
    localparam int RW       = RX_BYTES * 8;
    localparam int TW       = TX_BYTES * 8;
    localparam int CW       = $clog2(RX_TOTAL + 1);
    localparam int TCW      = $clog2(TX_TOTAL + 1);
    localparam int IW       = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state;
    state_t         state_d;
    logic [CW-1:0]  rx_cnt;
    logic [IW-1:0]  idle_cnt;
    logic [RW-1:0]  rx_shift;
    logic [RW-1:0]  frame_d;
    logic [TW-1:0]  tx_shift;
    logic [TCW-1:0] tx_cnt;
    logic [7:0]     tx_next;
    logic [15:0]    err_cnt_d;
    logic [1:0]     err_code;

    logic rx_act;
    logic strobe;
    logic timed_out;
    logic last_byte;
    logic eop_abort;
    logic rx_abort;
    logic payload_byte;
    logic msgid_bad;
    logic csum_bad;
    logic done;
    logic accept;
    logic reject;
    logic rx_clr;
    logic tx_fire;
    logic tx_shift_en;

    assign rx_act       = (state == S_RX);
    assign strobe       = rx_act && rx_byte_valid;
    assign timed_out    = rx_act && (rx_cnt != '0)
                          && (idle_cnt == IW'(TIMEOUT_CYCLES));
    assign last_byte    = strobe && (rx_cnt == CW'(RX_TOTAL - 1));
    // A final byte wins over a coincident end-of-packet.
    assign eop_abort    = rx_act && rx_eop && (rx_cnt != '0) && !last_byte;
    assign rx_abort     = timed_out || eop_abort;
    assign payload_byte = strobe && (rx_cnt < CW'(RX_BYTES));

    assign frame_d   = payload_byte ? {rx_shift[RW-9:0], rx_byte} : rx_shift;
    assign msgid_bad = MSGID_CHECK && (frame_d[RW-1 -: 32] != MSGID);

    assign done   = last_byte && !timed_out;
    assign accept = done && !msgid_bad && !csum_bad;
    assign reject = rx_abort || (done && !accept);
    assign rx_clr = reject || accept || !rx_act;

`ifdef UART_FRAME_CSUM_EN
    logic [7:0]        ck_hi;
    logic [CSUM_W-1:0] rx_sum;
    logic [CSUM_W-1:0] tx_sum;
    logic              rx_add;
    logic              tx_add;

    assign rx_add   = payload_byte && !rx_abort;
    assign tx_add   = tx_shift_en && (tx_cnt < TCW'(TX_BYTES));
    assign csum_bad = (rx_sum != {ck_hi, rx_byte});

    uart_frame_csum u_rx_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rx_clr),
        .add   (rx_add),
        .din   (rx_byte),
        .sum   (rx_sum)
    );

    uart_frame_csum u_tx_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .add   (tx_add),
        .din   (tx_shift[TW-1 -: 8]),
        .sum   (tx_sum)
    );

    always_comb begin
        tx_next = tx_shift[TW-1 -: 8];
        if (tx_cnt == TCW'(TX_BYTES)) begin
            tx_next = tx_sum[15:8];
        end else if (tx_cnt > TCW'(TX_BYTES)) begin
            tx_next = tx_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ck_hi <= '0;
        end else if (strobe && (rx_cnt == CW'(RX_BYTES))) begin
            ck_hi <= rx_byte;
        end
    end
`else
    assign csum_bad = 1'b0;
    assign tx_next  = tx_shift[TW-1 -: 8];
`endif

    always_comb begin
        err_code = ERR_NONE;
        if (rx_abort) begin
            err_code = ERR_TRUNC;
        end else if (msgid_bad) begin
            err_code = ERR_MSGID;
        end else if (csum_bad) begin
            err_code = ERR_CSUM;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt;
        if (reject && (err_cnt != 16'hFFFF)) begin
            err_cnt_d = err_cnt + 16'd1;
        end
    end

    always_comb begin
        state_d     = state;
        tx_fire     = 1'b0;
        tx_shift_en = 1'b0;
        unique case (state)
            S_RX: begin
                if (accept) begin
                    state_d = S_TX_SEND;
                end
            end
            S_TX_SEND: begin
                if (!tx_busy) begin
                    tx_fire = 1'b1;
                    state_d = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (tx_busy) begin
                    tx_shift_en = 1'b1;
                    if (tx_cnt == TCW'(TX_TOTAL - 1)) begin
                        state_d = S_TX_DRAIN;
                    end else begin
                        state_d = S_TX_SEND;
                    end
                end
            end
            S_TX_DRAIN: begin
                if (!tx_busy) begin
                    state_d = S_RX;
                end
            end
            default: state_d = S_RX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_RX;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            idle_cnt <= '0;
            rx_shift <= '0;
        end else if (rx_clr) begin
            rx_cnt   <= '0;
            idle_cnt <= '0;
        end else if (strobe) begin
            rx_cnt   <= rx_cnt + CW'(1);
            idle_cnt <= '0;
            rx_shift <= frame_d;
        end else if (rx_cnt != '0) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
        end else if (accept) begin
            tx_shift <= tx_data;
            tx_cnt   <= '0;
        end else if (tx_shift_en) begin
            tx_shift <= tx_shift << 8;
            tx_cnt   <= tx_cnt + TCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_byte   <= '0;
            tx_start  <= 1'b0;
            rx_data   <= '0;
            sync      <= 1'b0;
            tx_enable <= 1'b0;
            err_cnt   <= '0;
            last_err  <= ERR_NONE;
        end else begin
            sync     <= accept;
            tx_start <= tx_fire;
            err_cnt  <= err_cnt_d;
            if (tx_fire) begin
                tx_byte <= tx_next;
            end
            if (accept) begin
                rx_data   <= frame_d;
                tx_enable <= 1'b1;
            end else if (state == S_TX_DRAIN && !tx_busy) begin
                tx_enable <= 1'b0;
            end
            if (reject) begin
                last_err <= err_code;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame.sv
// Directed bench for uart_frame with a frame-level reference model.
// Build with UART_FRAME_CSUM_EN to exercise the checksum variant.
module tb_uart_frame;
    import uart_frame_pkg::*;

    localparam int          RXB = 10;
    localparam int          TXB = 10;
    localparam int          TO  = 1000;
    localparam logic [31:0] MID = 32'h74697277;
`ifdef UART_FRAME_CSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [7:0]      rx_byte;
    logic            rx_byte_valid;
    logic            rx_eop;
    logic            tx_busy;
    logic [TXB*8-1:0] tx_data;
    logic [7:0]      tx_byte;
    logic            tx_start;
    logic [RXB*8-1:0] rx_data;
    logic            sync;
    logic            tx_enable;
    logic [15:0]     err_cnt;
    logic [1:0]      last_err;

    int tests = 0;
    int fails = 0;

    logic [79:0] m_rx   = '0;
    logic [15:0] m_err  = '0;
    logic [1:0]  m_last = '0;
    int          m_sync = 0;
    int          seen_sync = 0;
    int          n_start = 0;
    logic [7:0]  m_tx[$];

    uart_frame #(
        .RX_BYTES       (RXB),
        .TX_BYTES       (TXB),
        .MSGID          (MID),
        .MSGID_CHECK    (1'b1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_eop        (rx_eop),
        .tx_busy       (tx_busy),
        .tx_data       (tx_data),
        .tx_byte       (tx_byte),
        .tx_start      (tx_start),
        .rx_data       (rx_data),
        .sync          (sync),
        .tx_enable     (tx_enable),
        .err_cnt       (err_cnt),
        .last_err      (last_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // TX PHY: busy for a few cycles after each start strobe.
    initial begin
        int cnt;
        cnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_busy = 1'b0;
            end else if (tx_start) begin
                tx_busy = 1'b1;
                cnt = 3;
            end
        end
    end

    // Per-cycle output checker against the model's byte queue.
    initial begin
        logic       prev_start;
        logic       prev_en;
        logic       pend;
        logic [7:0] held;
        prev_start = 1'b0;
        prev_en    = 1'b0;
        pend       = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (sync) seen_sync++;
            if (tx_start) begin
                n_start++;
                check("tx_start_gap", 80'(prev_start), 80'(0));
                if (m_tx.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_extra: got byte %0h expected none",
                             tx_byte);
                end else begin
                    check("tx_byte", 80'(tx_byte), 80'(m_tx.pop_front()));
                end
                held = tx_byte;
                pend = 1'b1;
            end else if (pend) begin
                if (tx_busy) pend = 1'b0;
                else check("tx_byte_hold", 80'(tx_byte), 80'(held));
            end
            if (prev_en && !tx_enable && rst_n) begin
                check("drain_queue", 80'(m_tx.size()), 80'(0));
                check("drain_busy", 80'(tx_busy), 80'(0));
            end
            prev_start = tx_start;
            prev_en    = tx_enable;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] bsum(input logic [7:0] q[$], input int n);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = s + 16'(q[i]);
        return s;
    endfunction

    task automatic send_raw(input logic [7:0] b[$], input bit eop_last);
        foreach (b[i]) begin
            @(negedge clk);
            rx_byte       = b[i];
            rx_byte_valid = 1'b1;
            rx_eop        = eop_last && (i == b.size() - 1);
            @(negedge clk);
            rx_byte_valid = 1'b0;
            rx_eop        = 1'b0;
        end
    endtask

    task automatic model_err(input logic [1:0] code);
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_last = code;
    endtask

    task automatic model_frame(input logic [7:0] f[$]);
        logic [31:0] id;
        logic [15:0] s;
        logic [15:0] ts;
        logic [7:0]  tq[$];
        bit          ck_ok;
        id = {f[0], f[1], f[2], f[3]};
        s  = bsum(f, RXB);
        ck_ok = 1'b1;
        if (CS) ck_ok = ({f[RXB], f[RXB+1]} == s);
        if (id != MID) begin
            model_err(ERR_MSGID);
        end else if (!ck_ok) begin
            model_err(ERR_CSUM);
        end else begin
            m_rx = '0;
            for (int i = 0; i < RXB; i++) m_rx = {m_rx[71:0], f[i]};
            m_sync++;
            for (int j = 0; j < TXB; j++) begin
                tq.push_back(tx_data[TXB*8-1-8*j -: 8]);
                m_tx.push_back(tx_data[TXB*8-1-8*j -: 8]);
            end
            ts = bsum(tq, TXB);
            if (CS) begin
                m_tx.push_back(ts[15:8]);
                m_tx.push_back(ts[7:0]);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] pl[$], input bit eop_last);
        logic [7:0]  f[$];
        logic [15:0] s;
        f = pl;
        s = bsum(pl, RXB);
        if (CS) begin
            f.push_back(s[15:8]);
            f.push_back(s[7:0]);
        end
        send_raw(f, eop_last);
        model_frame(f);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (tx_enable && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (tx_enable) begin
            tests++;
            fails++;
            $display("FAIL tx_done_timeout: got tx_enable 1 expected 0");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_model(input string nm);
        check({nm, "_rx_data"}, rx_data, m_rx);
        check({nm, "_err_cnt"}, 80'(err_cnt), 80'(m_err));
        check({nm, "_last_err"}, 80'(last_err), 80'(m_last));
        check({nm, "_sync"}, 80'(seen_sync), 80'(m_sync));
    endtask

    task automatic pulse_eop();
        @(negedge clk);
        rx_eop = 1'b1;
        @(negedge clk);
        rx_eop = 1'b0;
    endtask

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad[$];
        logic [7:0] part[$];
        logic [7:0] raw[$];
        int         base;
        int         k;

        good = '{8'h74, 8'h69, 8'h72, 8'h77, 8'h01,
                 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        bad  = '{8'h75, 8'h69, 8'h72, 8'h77, 8'h01,
                 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        rst_n = 1'b0;
        rx_byte = '0;
        rx_byte_valid = 1'b0;
        rx_eop = 1'b0;
        tx_data = 80'hA1B2C3D4E5F60718293A;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_rx_data", rx_data, 80'h0);
        check("rst_tx_start", 80'(tx_start), 80'(0));
        check("rst_tx_enable", 80'(tx_enable), 80'(0));
        check("rst_err_cnt", 80'(err_cnt), 80'(0));
        check("rst_last_err", 80'(last_err), 80'(0));
        check("rst_tx_byte", 80'(tx_byte), 80'(0));

        base = n_start;
        send_frame(good, 1'b0);
        check("accept_tx_enable", 80'(tx_enable), 80'(1));
        wait_done();
        check("good_rx_literal", rx_data, 80'h74697277010203040506);
        check("good_starts", 80'(n_start - base), 80'(TXB + (CS ? 2 : 0)));
        check_model("good");

        base = n_start;
        send_frame(bad, 1'b0);
        repeat (20) @(negedge clk);
        check("msgid_err_literal", 80'(err_cnt), 80'(1));
        check("msgid_last_literal", 80'(last_err), 80'(1));
        check("msgid_rx_hold", rx_data, 80'h74697277010203040506);
        check("msgid_no_start", 80'(n_start - base), 80'(0));
        check_model("msgid");

`ifdef UART_FRAME_CSUM_EN
        tx_data = 80'h0102030405060708090A;
        raw = '{8'h74, 8'h69, 8'h72, 8'h77, 8'h01, 8'h02,
                8'h03, 8'h04, 8'h05, 8'h49, 8'h02, 8'h1E};
        send_raw(raw, 1'b0);
        model_frame(raw);
        wait_done();
        check("csum_rx_literal", rx_data, 80'h74697277010203040549);
        check_model("csum_ok");
        raw[11] = 8'h1F;
        send_raw(raw, 1'b0);
        model_frame(raw);
        repeat (5) @(negedge clk);
        check("csum_last_literal", 80'(last_err), 80'(2));
        check_model("csum_bad");
`endif

        part = '{8'h74, 8'h69, 8'h72, 8'h77, 8'h01};
        send_raw(part, 1'b0);
        repeat (TO + 20) @(negedge clk);
        model_err(ERR_TRUNC);
        check("timeout_last_literal", 80'(last_err), 80'(3));
        check_model("timeout");
        tx_data = 80'h112233445566778899AA;
        send_frame(good, 1'b0);
        wait_done();
        check_model("after_timeout");

        part = '{8'h74, 8'h69, 8'h72};
        send_raw(part, 1'b0);
        pulse_eop();
        model_err(ERR_TRUNC);
        repeat (3) @(negedge clk);
        check_model("eop_abort");
        pulse_eop();
        repeat (3) @(negedge clk);
        check_model("eop_idle");
        send_frame(good, 1'b1);
        wait_done();
        check_model("eop_final");

        raw = good;
        if (CS) begin
            raw.push_back(8'h01);
            raw.push_back(8'hDB);
        end
        part = '{raw[0], raw[1], raw[2]};
        send_raw(part, 1'b0);
        repeat (TO - 100) @(negedge clk);
        part = raw[3:$];
        send_raw(part, 1'b0);
        model_frame(raw);
        wait_done();
        check_model("long_gap");

        tx_data = 80'hF0E1D2C3B4A596877869;
        send_frame(good, 1'b0);
        part = '{8'h75, 8'h01, 8'h02};
        send_raw(part, 1'b1);
        pulse_eop();
        check("half_duplex_en", 80'(tx_enable), 80'(1));
        wait_done();
        check_model("half_duplex");

        base = n_start;
        send_frame(good, 1'b0);
        k = 0;
        while (n_start < base + 4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("reach_4th_byte", 80'(n_start - base >= 4), 80'(1));
        rst_n = 1'b0;
        m_tx.delete();
        @(negedge clk);
        check("rst_mid_tx_start", 80'(tx_start), 80'(0));
        check("rst_mid_tx_enable", 80'(tx_enable), 80'(0));
        check("rst_mid_rx_data", rx_data, 80'h0);
        m_rx = '0;
        m_err = '0;
        m_last = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_model("post_reset");
        send_frame(good, 1'b0);
        wait_done();
        check_model("post_reset_frame");

        @(negedge clk);
        force dut.err_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt;
        m_err = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            part = '{8'h74};
            send_raw(part, 1'b0);
            pulse_eop();
            model_err(ERR_TRUNC);
        end
        repeat (3) @(negedge clk);
        check("sat_literal", 80'(err_cnt), 80'(16'hFFFF));
        check_model("saturate");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
